// File: rtl/ball_col_det_pkg.sv
// Shared game constants: coordinate widths, playfield geometry defaults,
// the per-target one-shot state encoding and small arithmetic helpers.
package ball_col_det_pkg;

   localparam int COORD_W = 12;           // pixel coordinate width
   localparam int DIFF_W  = COORD_W + 1;  // signed centre difference
   localparam int SQ_W    = 2 * DIFF_W;   // square of a difference
   localparam int DIST_W  = SQ_W + 1;     // dx^2 + dy^2 without truncation

   localparam int BALL_R_DEF  = 16;
   localparam int PL_R_DEF    = 32;
   localparam int NET_X_DEF   = 504;
   localparam int NET_W_DEF   = 16;
   localparam int NET_TOP_DEF = 420;

   typedef enum logic [1:0] {
      ARMED      = 2'd0,
      HOLD       = 2'd1,
      WAIT_CLEAR = 2'd2
   } col_state_e;

   // Signed difference of two unsigned coordinates, never overflows.
   function automatic logic signed [DIFF_W-1:0] coord_diff(
      input logic [COORD_W-1:0] a,
      input logic [COORD_W-1:0] b
   );
      return $signed({1'b0, a}) - $signed({1'b0, b});
   endfunction

   // Square of a signed difference; the result is always non-negative.
   function automatic logic [SQ_W-1:0] diff_sq(input logic signed [DIFF_W-1:0] v);
      logic signed [SQ_W-1:0] ve;
      ve = SQ_W'(v);
      return ve * ve;
   endfunction

endpackage

// File: rtl/ball_col_det_col_oneshot.sv
// Per-target one-shot: one pulse per contact, then a hold-off window, then
// the contact must clear before the target can fire again.
module col_oneshot
   import ball_col_det_pkg::*;
#(
   parameter int HOLDOFF_CYC = 500_000,
   parameter int CNT_W       = $clog2(HOLDOFF_CYC) + 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic hit,
   output logic pulse
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   col_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;

   // Next-state, hold-off counter and pulse decode; clr wins over everything.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      if (clr) begin
         state_d = ARMED;
         cnt_d   = CNT_ZERO;
      end else begin
         case (state_q)
            ARMED: begin
               if (hit) begin
                  state_d = HOLD;
                  cnt_d   = CNT_LOAD;
                  pulse_d = 1'b1;
               end else begin
                  state_d = ARMED;
               end
            end
            HOLD: begin
               if (cnt_q == CNT_ZERO) begin
                  state_d = WAIT_CLEAR;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            WAIT_CLEAR: begin
               if (!hit) begin
                  state_d = ARMED;
               end else begin
                  state_d = WAIT_CLEAR;
               end
            end
            default: begin
               state_d = ARMED;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end
   end

   // State, counter and registered pulse output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ARMED;
         cnt_q   <= CNT_ZERO;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/ball_col_det.sv
// Ball collision detector: 3-stage distance pipeline for two player blobs
// and the net, feeding one one-shot per target.
module ball_col_det
   import ball_col_det_pkg::*;
#(
   parameter int BALL_R      = BALL_R_DEF,
   parameter int PL_R        = PL_R_DEF,
   parameter int NET_X       = NET_X_DEF,
   parameter int NET_W       = NET_W_DEF,
   parameter int NET_TOP     = NET_TOP_DEF,
   parameter int HOLDOFF_CYC = 500_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COORD_W-1:0] ball_posx,
   input  logic [COORD_W-1:0] ball_posy,
   input  logic [COORD_W-1:0] pl1_posx,
   input  logic [COORD_W-1:0] pl1_posy,
   input  logic [COORD_W-1:0] pl2_posx,
   input  logic [COORD_W-1:0] pl2_posy,
   input  logic               en,
   output logic               pl1_col,
   output logic               pl2_col,
   output logic               net_col
);

   localparam logic [DIST_W-1:0] HIT_DIST2 = DIST_W'((PL_R + BALL_R) * (PL_R + BALL_R));
   // Net x-range is tested as bx+R >= NET_X so nothing underflows.
   localparam logic [DIFF_W-1:0] NET_LO    = DIFF_W'(NET_X);
   localparam logic [DIFF_W-1:0] NET_HI    = DIFF_W'(NET_X + NET_W - 1 + BALL_R);
   localparam logic [DIFF_W-1:0] BALL_R_W  = DIFF_W'(BALL_R);
   localparam logic [DIFF_W-1:0] NET_TOP_W = DIFF_W'(NET_TOP);

   // Stage 1: sampled ball position and centre differences.
   logic                     v1_q, v1_d;
   logic [COORD_W-1:0]       bx_q, bx_d, by_q, by_d;
   logic signed [DIFF_W-1:0] dx1_q, dx1_d, dy1_q, dy1_d;
   logic signed [DIFF_W-1:0] dx2_q, dx2_d, dy2_q, dy2_d;
   // Stage 2: squared distances and net contact.
   logic                     v2_q, v2_d;
   logic [DIST_W-1:0]        dist1_q, dist1_d, dist2_q, dist2_d;
   logic                     net_q, net_d;
   // Stage 3 inputs to the one-shots.
   logic                     hit1_s, hit2_s, hitn_s;
   logic                     clr_s;

   // Stage 1 next values: capture the ball and the signed differences.
   always_comb begin
      v1_d  = en;
      bx_d  = ball_posx;
      by_d  = ball_posy;
      dx1_d = coord_diff(ball_posx, pl1_posx);
      dy1_d = coord_diff(ball_posy, pl1_posy);
      dx2_d = coord_diff(ball_posx, pl2_posx);
      dy2_d = coord_diff(ball_posy, pl2_posy);
   end

   // Stage 2 next values: full-width distance sums and the net window test.
   always_comb begin
      v2_d    = v1_q & en;
      dist1_d = {1'b0, diff_sq(dx1_q)} + {1'b0, diff_sq(dy1_q)};
      dist2_d = {1'b0, diff_sq(dx2_q)} + {1'b0, diff_sq(dy2_q)};
      net_d   = (({1'b0, bx_q} + BALL_R_W) >= NET_LO) &&
                ({1'b0, bx_q} <= NET_HI) &&
                (({1'b0, by_q} + BALL_R_W) >= NET_TOP_W);
   end

   // Pipeline registers for both stages.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q    <= 1'b0;
         bx_q    <= {COORD_W{1'b0}};
         by_q    <= {COORD_W{1'b0}};
         dx1_q   <= {DIFF_W{1'b0}};
         dy1_q   <= {DIFF_W{1'b0}};
         dx2_q   <= {DIFF_W{1'b0}};
         dy2_q   <= {DIFF_W{1'b0}};
         v2_q    <= 1'b0;
         dist1_q <= {DIST_W{1'b0}};
         dist2_q <= {DIST_W{1'b0}};
         net_q   <= 1'b0;
      end else begin
         v1_q    <= v1_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         dx1_q   <= dx1_d;
         dy1_q   <= dy1_d;
         dx2_q   <= dx2_d;
         dy2_q   <= dy2_d;
         v2_q    <= v2_d;
         dist1_q <= dist1_d;
         dist2_q <= dist2_d;
         net_q   <= net_d;
      end
   end

   assign hit1_s = v2_q & (dist1_q <= HIT_DIST2);
   assign hit2_s = v2_q & (dist2_q <= HIT_DIST2);
   assign hitn_s = v2_q & net_q;
   assign clr_s  = ~en;

   col_oneshot #(.HOLDOFF_CYC(HOLDOFF_CYC)) u_os_pl1 (
      .clk(clk), .rst(rst), .clr(clr_s), .hit(hit1_s), .pulse(pl1_col)
   );
   col_oneshot #(.HOLDOFF_CYC(HOLDOFF_CYC)) u_os_pl2 (
      .clk(clk), .rst(rst), .clr(clr_s), .hit(hit2_s), .pulse(pl2_col)
   );
   col_oneshot #(.HOLDOFF_CYC(HOLDOFF_CYC)) u_os_net (
      .clk(clk), .rst(rst), .clr(clr_s), .hit(hitn_s), .pulse(net_col)
   );

endmodule

// File: tb/tb_ball_col_det.sv
// Bench for ball_col_det: directed scenarios plus randomized play, with a
// queue-based scoreboard fed by a rule-level reference model.
module tb_ball_col_det;

   localparam int HOLDOFF = 8;
   localparam int BR = 16;
   localparam int PR = 32;
   localparam int NX = 504;
   localparam int NW = 16;
   localparam int NT = 420;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b0;
   logic [11:0] ball_posx = 12'd0, ball_posy = 12'd0;
   logic [11:0] pl1_posx = 12'd0, pl1_posy = 12'd0, pl2_posx = 12'd0, pl2_posy = 12'd0;
   logic        pl1_col, pl2_col, net_col;

   ball_col_det #(.HOLDOFF_CYC(HOLDOFF)) dut (
      .clk(clk), .rst(rst),
      .ball_posx(ball_posx), .ball_posy(ball_posy),
      .pl1_posx(pl1_posx), .pl1_posy(pl1_posy),
      .pl2_posx(pl2_posx), .pl2_posy(pl2_posy),
      .en(en),
      .pl1_col(pl1_col), .pl2_col(pl2_col), .net_col(net_col)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int pulses[3] = '{0, 0, 0};     // observed pl1, pl2, net pulses
   logic [2:0] exp_q[$];           // {pl1, pl2, net} expected after each edge

   // Reference model: contact history and per-target hold-off bookkeeping.
   bit [2:0] c_m1 = 3'b000, c_m2 = 3'b000;
   bit       en_m1 = 1'b0, en_m2 = 1'b0;
   int       edge_no = 0;
   int       ign_until[3] = '{0, 0, 0};
   bit       need_clear[3] = '{1'b0, 1'b0, 1'b0};
   bit       rst_prev = 1'b0;

   // Current directed stimulus context.
   int p1x = 180, p1y = 373, p2x = 1000, p2y = 100;
   bit en_v = 1'b0, rst_v = 1'b0;

   task automatic chk(input string name, input int got, input int req);
      n_checks++;
      if (got == req) n_pass++;
      else $display("FAIL %s at %0t: got %0d, required %0d", name, $time, got, req);
   endtask

   function automatic bit pl_touch(input int bx, input int by, input int px, input int py);
      int dx, dy;
      dx = bx - px;
      dy = by - py;
      return (dx * dx + dy * dy) <= (PR + BR) * (PR + BR);
   endfunction

   function automatic bit net_touch(input int bx, input int by);
      return (bx >= NX - BR) && (bx <= NX + NW - 1 + BR) && (by + BR >= NT);
   endfunction

   // One clock of stimulus: drive at negedge, predict the output after the next edge.
   task automatic step(input int bx, input int by, input int ax, input int ay,
                       input int qx, input int qy, input bit en_i, input bit rst_i);
      bit [2:0] c_now, hitv, e;
      @(negedge clk);
      ball_posx = 12'(bx); ball_posy = 12'(by);
      pl1_posx  = 12'(ax); pl1_posy  = 12'(ay);
      pl2_posx  = 12'(qx); pl2_posy  = 12'(qy);
      en  = en_i;
      rst = rst_i;
      c_now = {pl_touch(bx, by, ax, ay), pl_touch(bx, by, qx, qy), net_touch(bx, by)};
      e = 3'b000;
      edge_no++;
      if (!rst_i) begin
         c_m1 = 3'b000; c_m2 = 3'b000; en_m1 = 1'b0; en_m2 = 1'b0;
         for (int i = 0; i < 3; i++) begin
            ign_until[i] = 0; need_clear[i] = 1'b0;
         end
      end else begin
         // A sample counts only if detection stayed enabled while it travelled.
         hitv = (en_m2 && en_m1) ? c_m2 : 3'b000;
         for (int i = 0; i < 3; i++) begin
            if (!en_i) begin
               ign_until[i] = 0; need_clear[i] = 1'b0;
            end else if (edge_no <= ign_until[i]) begin
               // inside hold-off window
            end else if (need_clear[i]) begin
               if (!hitv[2-i]) need_clear[i] = 1'b0;
            end else if (hitv[2-i]) begin
               e[2-i]        = 1'b1;
               ign_until[i]  = edge_no + HOLDOFF;
               need_clear[i] = 1'b1;
            end
         end
         c_m2 = c_m1; c_m1 = c_now;
         en_m2 = en_m1; en_m1 = en_i;
      end
      exp_q.push_back(e);
      if (!rst_i && rst_prev) begin
         #1;
         chk("async_reset_clear", int'({pl1_col, pl2_col, net_col}), 0);
      end
      rst_prev = rst_i;
   endtask

   task automatic drive(input int bx, input int by, input int n);
      repeat (n) step(bx, by, p1x, p1y, p2x, p2y, en_v, rst_v);
   endtask

   task automatic idle(input int n);
      drive(1500, 100, n);
   endtask

   // Monitor: after every edge compare the DUT outputs with the oldest prediction.
   initial begin
      logic [2:0] e, got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {pl1_col, pl2_col, net_col};
            chk("scoreboard_pl1_pl2_net", int'(got), int'(e));
            pulses[0] += int'(got[2]);
            pulses[1] += int'(got[1]);
            pulses[2] += int'(got[0]);
         end
      end
   end

   initial begin
      int s0, s1, s2, hold_n, bx, by;
      rst_v = 1'b0; en_v = 1'b1;
      idle(3);
      chk("reset_outputs", int'({pl1_col, pl2_col, net_col}), 0);
      rst_v = 1'b1;
      idle(4);

      // Player 1 distance boundary.
      s0 = pulses[0];
      drive(180, 325, 1); idle(14);
      chk("pl1_dy48_pulse", pulses[0] - s0, 1);
      s0 = pulses[0];
      drive(180, 324, 1); idle(14);
      chk("pl1_dy49_none", pulses[0] - s0, 0);

      // Sustained contact, then a brief clear re-arms.
      s0 = pulses[0];
      drive(180, 340, 50);
      chk("sustained_one_pulse", pulses[0] - s0, 1);
      drive(180, 100, 1);
      drive(180, 340, 5); idle(14);
      chk("rearm_second_pulse", pulses[0] - s0, 2);

      // Net edges.
      s2 = pulses[2]; drive(488, 404, 1); idle(14); chk("net_left_edge", pulses[2] - s2, 1);
      s2 = pulses[2]; drive(487, 404, 1); idle(14); chk("net_left_out", pulses[2] - s2, 0);
      s2 = pulses[2]; drive(535, 404, 1); idle(14); chk("net_right_edge", pulses[2] - s2, 1);
      s2 = pulses[2]; drive(500, 403, 1); idle(14); chk("net_above_top", pulses[2] - s2, 0);

      // Simultaneous player contacts.
      p1x = 180; p1y = 325; p2x = 180; p2y = 325;
      s0 = pulses[0]; s1 = pulses[1]; s2 = pulses[2];
      drive(180, 325, 1); idle(14);
      chk("simul_pl1", pulses[0] - s0, 1);
      chk("simul_pl2", pulses[1] - s1, 1);
      chk("simul_net", pulses[2] - s2, 0);
      p1x = 180; p1y = 373; p2x = 1000; p2y = 100;

      // Reset in the middle of the hold-off window.
      s0 = pulses[0];
      drive(180, 340, 6);
      rst_v = 1'b0; drive(180, 340, 2);
      rst_v = 1'b1; drive(180, 340, 6);
      chk("reset_discards_holdoff", pulses[0] - s0, 2);
      idle(14);

      // Disabled detection suppresses pulses; enabling fires after the latency.
      en_v = 1'b0;
      s0 = pulses[0];
      drive(180, 340, 10);
      chk("disabled_no_pulse", pulses[0] - s0, 0);
      en_v = 1'b1;
      drive(180, 340, 6);
      chk("enable_pulse", pulses[0] - s0, 1);
      idle(14);

      // Randomized play around the players and the net.
      hold_n = 0; bx = 0; by = 0;
      for (int k = 0; k < 3000; k++) begin
         if ((k % 64) == 0) begin
            p1x = int'($urandom_range(100, 3000)); p1y = int'($urandom_range(100, 3000));
            p2x = int'($urandom_range(100, 3000)); p2y = int'($urandom_range(100, 3000));
            if ($urandom_range(0, 3) == 0) begin p2x = p1x + 20; p2y = p1y; end
         end
         if (hold_n == 0) begin
            hold_n = int'($urandom_range(1, 20));
            case ($urandom_range(0, 3))
               0: begin bx = p1x + int'($urandom_range(0, 110)) - 55; by = p1y + int'($urandom_range(0, 110)) - 55; end
               1: begin bx = p2x + int'($urandom_range(0, 110)) - 55; by = p2y + int'($urandom_range(0, 110)) - 55; end
               2: begin bx = int'($urandom_range(480, 545)); by = int'($urandom_range(395, 430)); end
               default: begin bx = int'($urandom_range(0, 4095)); by = int'($urandom_range(0, 4095)); end
            endcase
         end
         hold_n--;
         if (en_v && $urandom_range(0, 99) < 2) en_v = 1'b0;
         else if (!en_v && $urandom_range(0, 99) < 30) en_v = 1'b1;
         rst_v = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         drive(bx, by, 1);
      end
      rst_v = 1'b1; en_v = 1'b1;
      p1x = 180; p1y = 373; p2x = 1000; p2y = 100;
      idle(4);

      @(posedge clk);
      #2;
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ball_col_det.md
BALL_COL_DET -- requirements
Module: ball_col_det

Interface
REQ-001 Parameter BALL_R, default 16: ball radius in pixels; ball_posx/ball_posy give the ball centre.
REQ-002 Parameter PL_R, default 32: player blob radius in pixels; pl*_posx/pl*_posy give the blob centre.
REQ-003 Parameter NET_X, default 504: net left edge x.
REQ-004 Parameter NET_W, default 16: net width in pixels.
REQ-005 Parameter NET_TOP, default 420: net top y; y grows downward.
REQ-006 Parameter HOLDOFF_CYC, default 500_000: minimum clocks between two pulses for one target.
REQ-007 One clock; reset is asynchronous and active-low.
REQ-008 clk  in  1  system clock; all state rises on its posedge.
REQ-009 rst  in  1  asynchronous, active-low reset.
REQ-010 ball_posx, ball_posy  in  12 each  ball centre, unsigned pixels.
REQ-011 pl1_posx, pl1_posy, pl2_posx, pl2_posy  in  12 each  player centres, unsigned.
REQ-012 en  in  1  detection enable; 0 = idle, used between rallies.
REQ-013 pl1_col, pl2_col, net_col  out  1 each  single-cycle collision pulses, fed to the ball position controller.

Function
REQ-014 Raw player contact SHALL be true when dx*dx + dy*dy <= (PL_R+BALL_R)^2, with dx and dy as the signed 13-bit centre differences and the sum kept at 27 bits with no truncation.
REQ-015 Raw net contact SHALL be true when ball_posx is in [NET_X-BALL_R, NET_X+NET_W-1+BALL_R] and ball_posy+BALL_R >= NET_TOP. The sum is at 13 bits and the comparisons are unsigned-safe, so there is no underflow.
REQ-016 The pipeline SHALL be 3 stages:
  - S1 registers the inputs and differences.
  - S2 registers the squares and the sum.
  - S3 registers the compare result into the per-target FSM.
  - Output pulse latency from input sample is 3 clocks.
REQ-017 Each of the 3 targets SHALL have an independent FSM with states ARMED, HOLD and WAIT_CLEAR.
REQ-018 ARMED with raw contact true SHALL go to HOLD, load the counter with HOLDOFF_CYC-1, and assert the target pulse for exactly that one cycle.
REQ-019 HOLD SHALL decrement the counter each clock and go to WAIT_CLEAR when the counter reaches 0; it asserts no pulse.
REQ-020 WAIT_CLEAR SHALL return to ARMED on the first cycle with raw contact false; a sustained contact never produces a second pulse.
REQ-021 Simultaneous contacts SHALL pulse independently; pl1_col, pl2_col and net_col may be high in the same cycle.
REQ-022 While en=0, all FSMs SHALL be forced to ARMED, counters cleared, outputs 0 and the pipeline valid bits cleared.
REQ-023 After en rises, no pulse SHALL appear before 3 clocks have elapsed.
REQ-024 The counter width SHALL be $clog2(HOLDOFF_CYC)+1, and the counter SHALL NOT wrap.
REQ-025 Inputs are sampled every clock; they need not be stable between samples.

Reset
REQ-026 rst=0 SHALL asynchronously clear:
  - pl1_col, pl2_col and net_col to 0;
  - all FSMs to ARMED and all counters to 0;
  - all pipeline registers and valid bits to 0.
REQ-027 Reset asserted mid-HOLD SHALL discard the hold-off; the first valid contact after release pulses after the 3-clock latency.
REQ-028 Reset release is synchronous-deasserted by an upstream synchroniser; the block adds none.

Structure
REQ-029 The geometry defaults (BALL_R, PL_R, NET_X, NET_W, NET_TOP), the coordinate width of 12 and the FSM state encoding SHALL reside in the shared game constants package.
REQ-030 The per-target FSM plus hold-off counter SHALL be the sub-module col_oneshot, instantiated 3 times.
REQ-031 The distance arithmetic stays in ball_col_det.

Verification (bench uses HOLDOFF_CYC=8)
REQ-032 Player 1 boundary: pl1 at (180,373), ball at (180,325), dy=48 -> pl1_col pulses once, 3 clocks after sampling. Ball at (180,324), dy=49 -> no pulse.
REQ-033 Sustained contact: ball at (180,340) held for 50 clocks -> exactly 1 pl1_col pulse. Move the ball to (180,100) for 1 clock, then back to (180,340) after HOLD has ended -> second pulse.
REQ-034 Net edges:
  - ball (488,404) -> net_col;
  - ball (487,404) -> none;
  - ball (535,404) -> net_col;
  - ball (500,403) -> none.
REQ-035 Simultaneous: pl1 (180,325), pl2 (180,325), ball (180,325) -> pl1_col and pl2_col high in the same cycle, net_col 0.
REQ-036 rst=0 in the 4th HOLD cycle -> all outputs 0 immediately. After release with contact held, pl1_col pulses at clock 3.
REQ-037 en=0 with contact present -> outputs stay 0. Raise en -> pulse at clock 3 after en rises.
